// File: rtl/seq_detect_ctrl_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package seq_detect_ctrl_pkg;

    // Controller states: waiting for a legal config, detecting, holding on irq.
    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Widest mask the helper can produce; callers truncate to their MAX_LEN.
    localparam int MASK_W = 32;

    // Low-order mask with the bottom 'len' bits set (len >= MASK_W gives all ones).
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_history_matcher.sv
// Serial history shift register with a saturating fill counter and a masked
// comparator. 'match' is combinational and refers to the bit being shifted in
// this cycle, so the controller can register the result at the same edge.
module seq_history_matcher
    import seq_detect_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               match
);

    logic [MAX_LEN-1:0] history_q, history_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] new_history;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W:0]     fill_next;
    logic               fill_ok;

    // Next history/fill and the match decision for the incoming bit.
    always_comb begin
        new_history = {history_q[MAX_LEN-2:0], bit_in};
        mask        = MAX_LEN'(len_mask(int'(len)));
        fill_next   = {1'b0, fill_q} + {{LEN_W{1'b0}}, 1'b1};
        // Do not match on reset-zero history before len real bits have arrived.
        fill_ok     = fill_next >= {1'b0, len};
        match       = shift_en && fill_ok && (((new_history ^ pattern) & mask) == '0);

        history_d = history_q;
        fill_d    = fill_q;
        if (clear) begin
            history_d = '0;
            fill_d    = '0;
        end else if (shift_en) begin
            history_d = new_history;
            if (fill_q < LEN_W'(MAX_LEN)) begin
                fill_d = fill_next[LEN_W-1:0];
            end
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history_q <= '0;
            fill_q    <= '0;
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detection controller: config handshake,
// overlapping match detection, match counting and a held threshold interrupt.
// Handshake: a config is taken on any cycle where cfg_valid && cfg_ready;
// cfg_ready is low only while ARMED with detection enabled.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_threshold,
    output logic               cfg_err,
    input  logic               en,
    input  logic               a_valid,
    input  logic               a,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               irq,
    input  logic               irq_ack,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic               det_q, det_d;
    logic               err_q, err_d;

    logic               cfg_fire;
    logic               cfg_legal;
    logic               hold_ack;
    logic               shift_en;
    logic               hist_clear;
    logic               match;
    logic [CNT_W-1:0]   cnt_inc;

    assign cfg_ready   = (state_q != ARMED) || !en;
    assign busy        = (state_q == ARMED);
    assign detected    = det_q;
    assign match_count = cnt_q;
    assign irq         = irq_q;
    assign cfg_err     = err_q;
    assign dbg_state   = state_q;

    seq_history_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk      (clk),
        .rst      (rst),
        .clear    (hist_clear),
        .shift_en (shift_en),
        .bit_in   (a),
        .pattern  (pattern_q),
        .len      (len_q),
        .match    (match)
    );

    // Control decisions: config wins over ack and stream bits in the same cycle.
    always_comb begin
        cfg_fire   = cfg_valid && cfg_ready;
        cfg_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN)) && (cfg_threshold != '0);
        hold_ack   = (state_q == HOLD) && irq_ack && !cfg_fire;
        shift_en   = !cfg_fire && (state_q == ARMED) && a_valid && en;
        hist_clear = cfg_fire || hold_ack;
        cnt_inc    = cnt_q + CNT_W'(1);

        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        thr_d     = thr_q;
        cnt_d     = cnt_q;
        irq_d     = irq_q;
        det_d     = 1'b0;
        err_d     = 1'b0;

        if (cfg_fire) begin
            pattern_d = cfg_pattern;
            len_d     = cfg_len;
            thr_d     = cfg_threshold;
            cnt_d     = '0;
            irq_d     = 1'b0;
            state_d   = cfg_legal ? ARMED : UNCFG;
            err_d     = !cfg_legal;
        end else if (shift_en && match) begin
            det_d = 1'b1;
            cnt_d = cnt_inc;
            // Reaching the threshold stops counting, so the counter never wraps.
            if (cnt_inc == thr_q) begin
                irq_d   = 1'b1;
                state_d = HOLD;
            end
        end else if (hold_ack) begin
            irq_d   = 1'b0;
            cnt_d   = '0;
            state_d = ARMED;
        end
    end

    // State, config, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= UNCFG;
            pattern_q <= '0;
            len_q     <= '0;
            thr_q     <= '0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
            det_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            thr_q     <= thr_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
            det_q     <= det_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed stream vectors, a bit-queue reference
// model compared every cycle, and hand-computed spot checks.
module tb_seq_detect_ctrl;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    // Clock and reset.
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic [CNT_W-1:0]   cfg_threshold = '0;
    logic               cfg_err;
    logic               en = 1'b1;
    logic               a_valid = 1'b0;
    logic               a = 1'b0;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic               irq;
    logic               irq_ack = 1'b0;
    logic               busy;
    logic [1:0]         dbg_state;

    seq_detect_ctrl #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_threshold (cfg_threshold),
        .cfg_err       (cfg_err),
        .en            (en),
        .a_valid       (a_valid),
        .a             (a),
        .detected      (detected),
        .match_count   (match_count),
        .irq           (irq),
        .irq_ack       (irq_ack),
        .busy          (busy),
        .dbg_state     (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = unconfigured, 1 = detecting, 2 = holding.
    int                 m_mode = 0;
    int                 m_bits[$];
    logic [MAX_LEN-1:0] m_pat = '0;
    int                 m_len = 0;
    int                 m_thr = 0;
    int                 m_cnt = 0;
    int                 m_irq = 0;
    int                 m_det = 0;
    int                 m_err = 0;

    function automatic int tail_match();
        if (m_bits.size() < m_len) return 0;
        for (int i = 0; i < m_len; i++) begin
            if (m_bits[m_bits.size() - 1 - i] != int'(m_pat[i])) return 0;
        end
        return 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_bits.delete(); m_cnt = 0; m_irq = 0; m_det = 0; m_err = 0;
        end else begin
            m_det = 0;
            m_err = 0;
            if (cfg_valid && ((m_mode != 1) || !en)) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_thr = int'(cfg_threshold);
                m_bits.delete();
                m_cnt = 0;
                m_irq = 0;
                if (cfg_len == 0 || int'(cfg_len) > MAX_LEN || cfg_threshold == 0) begin
                    m_err = 1; m_mode = 0;
                end else begin
                    m_mode = 1;
                end
            end else if (m_mode == 1 && en && a_valid) begin
                m_bits.push_back(int'(a));
                if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
                if (tail_match() != 0) begin
                    m_det = 1;
                    m_cnt++;
                    if (m_cnt == m_thr) begin
                        m_irq = 1; m_mode = 2;
                    end
                end
            end else if (m_mode == 2 && irq_ack) begin
                m_irq = 0; m_cnt = 0; m_bits.delete(); m_mode = 1;
            end
        end
    end

    // Every-cycle compare, shortly after each active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cyc_detected", int'(detected), m_det);
            chk("cyc_match_count", int'(match_count), m_cnt);
            chk("cyc_irq", int'(irq), m_irq);
            chk("cyc_cfg_err", int'(cfg_err), m_err);
            chk("cyc_busy", int'(busy), (m_mode == 1) ? 1 : 0);
            chk("cyc_cfg_ready", int'(cfg_ready), ((m_mode != 1) || !en) ? 1 : 0);
        end
    end

    // Driver tasks: called at a negedge, return at the following negedge.
    task automatic cycle();
        @(negedge clk);
        a_valid   = 1'b0;
        cfg_valid = 1'b0;
        irq_ack   = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        a_valid = 1'b1;
        a       = b;
        cycle();
    endtask

    task automatic send_bits(input int n, input logic [15:0] v);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_cfg(input logic [MAX_LEN-1:0] pat, input int len, input int thr);
        cfg_valid     = 1'b1;
        cfg_pattern   = pat;
        cfg_len       = LEN_W'(len);
        cfg_threshold = CNT_W'(thr);
        cycle();
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        cycle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_count", int'(match_count), 0);

        // Basic match, latency and one-cycle pulse.
        do_cfg(8'b1010, 4, 3);
        chk("t1_busy", int'(busy), 1);
        chk("t1_cfg_err", int'(cfg_err), 0);
        send_bits(3, 16'b101);
        chk("t1_no_early_det", int'(detected), 0);
        send_bit(1'b0);
        chk("t1_det", int'(detected), 1);
        chk("t1_count", int'(match_count), 1);
        chk("t1_irq", int'(irq), 0);
        cycle();
        chk("t1_det_pulse", int'(detected), 0);
        ack();
        chk("t1_ack_ignored", int'(match_count), 1);
        do_cfg(8'b1111, 4, 1);
        chk("t1_cfg_blocked", int'(match_count), 1);

        // Overlapping match.
        send_bit(1'b1);
        chk("t2_det_odd", int'(detected), 0);
        send_bit(1'b0);
        chk("t2_det", int'(detected), 1);
        chk("t2_count", int'(match_count), 2);

        // Enable low freezes history and keeps cfg_ready up.
        en = 1'b0;
        send_bits(4, 16'b0101);
        chk("t2_en_count", int'(match_count), 2);
        chk("t2_en_ready", int'(cfg_ready), 1);
        en = 1'b1;

        // Third match raises irq and holds.
        send_bits(2, 16'b10);
        chk("t3_det", int'(detected), 1);
        chk("t3_count", int'(match_count), 3);
        chk("t3_irq", int'(irq), 1);
        chk("t3_busy", int'(busy), 0);
        send_bits(4, 16'b1010);
        chk("t3_hold_det", int'(detected), 0);
        chk("t3_hold_count", int'(match_count), 3);
        ack();
        chk("t3_ack_irq", int'(irq), 0);
        chk("t3_ack_count", int'(match_count), 0);
        send_bits(3, 16'b010);
        chk("t3_fill_guard", int'(match_count), 0);
        send_bits(4, 16'b1010);
        chk("t3_rematch", int'(match_count), 2);

        // All-zero pattern straight after reset.
        pulse_reset();
        do_cfg(8'b000, 3, 5);
        send_bit(1'b0);
        chk("t4_bit1", int'(detected), 0);
        send_bit(1'b0);
        chk("t4_bit2", int'(detected), 0);
        send_bit(1'b0);
        chk("t4_bit3", int'(detected), 1);
        en = 1'b0;
        do_cfg(8'b110011, 6, 5);
        chk("t4_recfg_count", int'(match_count), 0);
        en = 1'b1;
        send_bits(6, 16'b110011);
        chk("t4_len6_det", int'(detected), 1);
        chk("t4_len6_count", int'(match_count), 1);

        // Illegal configurations.
        pulse_reset();
        do_cfg(8'b1010, 0, 3);
        chk("t5_err_len0", int'(cfg_err), 1);
        chk("t5_busy_len0", int'(busy), 0);
        cycle();
        chk("t5_err_pulse", int'(cfg_err), 0);
        send_bits(4, 16'b1010);
        chk("t5_no_det", int'(match_count), 0);
        do_cfg(8'b101, 3, 0);
        chk("t5_err_thr0", int'(cfg_err), 1);
        do_cfg(8'hAA, 9, 2);
        chk("t5_err_len9", int'(cfg_err), 1);
        send_bits(8, 16'hAA);
        chk("t5_no_det2", int'(match_count), 0);

        // Asynchronous reset between edges while irq is up.
        do_cfg(8'b1010, 4, 2);
        send_bits(4, 16'b1010);
        chk("t6_count", int'(match_count), 1);
        send_bits(2, 16'b10);
        chk("t6_irq", int'(irq), 1);
        chk("t6_det", int'(detected), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_irq", int'(irq), 0);
        chk("t6_rst_det", int'(detected), 0);
        chk("t6_rst_count", int'(match_count), 0);
        chk("t6_rst_ready", int'(cfg_ready), 1);
        #1 rst = 1'b0;
        cycle();
        send_bits(4, 16'b1010);
        chk("t6_unconfigured", int'(match_count), 0);
        chk("t6_unconfigured_det", int'(detected), 0);

        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
